// File: rtl/sram_master_if.sv
// Host-side request/response channel of the SRAM controller.
// The host owns the master modport, the controller owns the slave modport.
interface sram_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [12:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_master.sv
// Single-transaction asynchronous SRAM controller: SETUP -> STROBE -> HOLD,
// with separately timed address/data setup and strobe widths.
module sram_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  sram_master_if.slave host,
  output logic [12:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_we,
  output logic        sram_re
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_write;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        drive_en;
  logic        accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // sram_addr is the latched address itself, so it naturally holds in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_write  <= 1'b0;
      wdata_q   <= '0;
      sram_addr <= '0;
    end else if (accept) begin
      op_write  <= host.req_write;
      wdata_q   <= host.req_wdata;
      sram_addr <= host.req_addr;
    end
  end

  // Sample the bus on the edge that closes the final strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rdata_q <= '0;
    else if (state == STROBE && cnt == 4'd0 && !op_write)
      rdata_q <= sram_data;
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    accept         = 1'b0;
    drive_en       = 1'b0;
    sram_we        = 1'b0;
    sram_re        = 1'b0;
    host.req_ready = 1'b0;
    host.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        host.req_ready = 1'b1;
        if (host.req_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: begin
        drive_en = op_write;
        if (cnt == 4'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        drive_en = op_write;
        sram_we  = op_write;
        sram_re  = !op_write;
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        drive_en       = op_write;
        host.rsp_valid = !op_write;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign host.rsp_rdata = rdata_q;
  assign sram_data      = drive_en ? wdata_q : 8'bz;

endmodule
